// File: rtl/sys1_input_pkg.sv
`default_nettype none
// ============================================================================
// sys1_input_pkg : joystick/SYSMODE bit indices and coin FSM state type
// Rev 1.0
// ============================================================================
package sys1_input_pkg;

  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_TRIG1  = 4;
  localparam int JOY_TRIG2  = 5;
  localparam int JOY_TRIG3  = 6;
  localparam int JOY_START1 = 7;
  localparam int JOY_START2 = 8;
  localparam int JOY_COIN   = 11;
  localparam int JOY_PAUSE  = 12;

  localparam int SYSMODE_WATER = 3;
  localparam int SYSMODE_SPIN  = 5;
  localparam int SYSMODE_SWAP  = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    LOCKOUT = 2'd2
  } coin_state_t;

endpackage

`default_nettype wire

// File: rtl/sys1_coin_shaper.sv
`default_nettype none
// ============================================================================
// sys1_coin_shaper : one coin pulse per press, COIN_FRAMES frame ticks wide
// Rev 1.0
// ============================================================================
module sys1_coin_shaper
  import sys1_input_pkg::*;
#(
  parameter int COIN_FRAMES = 3
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic coin_i,
  input  logic frame_tick_i,
  output logic coin_active_o
);

  localparam int CW = $clog2(COIN_FRAMES + 1);

  coin_state_t   state_q;
  logic [CW-1:0] cnt_q;
  logic          coin_prev_q;
  logic          tick_seen_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      coin_prev_q   <= 1'b0;
      tick_seen_q   <= 1'b0;
      coin_active_o <= 1'b0;
    end else begin
      coin_prev_q <= coin_i;
      case (state_q)
        IDLE: begin
          if (coin_i && !coin_prev_q) begin
            state_q       <= ACTIVE;
            cnt_q         <= '0;
            coin_active_o <= 1'b1;
          end
        end
        ACTIVE: begin
          if (frame_tick_i) begin
            if (cnt_q == CW'(COIN_FRAMES - 1)) begin
              state_q       <= LOCKOUT;
              cnt_q         <= '0;
              tick_seen_q   <= 1'b0;
              coin_active_o <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        LOCKOUT: begin
          // Re-arm only after the button is up and a frame has passed.
          if (frame_tick_i) tick_seen_q <= 1'b1;
          if (!coin_i && (tick_seen_q || frame_tick_i)) begin
            state_q     <= IDLE;
            tick_seen_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          coin_active_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sys1_input_conditioner.sv
`default_nettype none
// ============================================================================
// sys1_input_conditioner : hps_io inputs -> SEGASYSTEM1 INP0..2, pause, dim
// Optional trig1 autofire when INP_AUTOFIRE_EN is defined.  Rev 1.0
// ============================================================================
module sys1_input_conditioner
  import sys1_input_pkg::*;
#(
  parameter int COIN_FRAMES = 3,
  parameter int DIM_CYCLES  = 400_000_000,
  parameter int AF_FRAMES   = 4
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       vs_strobe_i,
  input  logic [15:0] joy1_i,
  input  logic [15:0] joy2_i,
  input  logic [7:0] spin_i,
  input  logic [2:0] mouse_btn_i,
  input  logic [7:0] sysmode_i,
  input  logic       osd_pause_i,
  input  logic       hs_access_i,
  input  logic       af_enable_i,
  output logic [7:0] inp0_o,
  output logic [7:0] inp1_o,
  output logic [7:0] inp2_o,
  output logic       pause_o,
  output logic       dim_video_o
);

  localparam int SW = 37;
  localparam int DW = $clog2(DIM_CYCLES + 1);

  logic [SW-1:0] sync1_q, sync2_q;
  logic [15:0]   joy1_s, joy2_s, joy;
  logic [2:0]    mouse_s;
  logic          vs_s, osd_s;
  logic          vs_prev_q, pause_btn_prev_q, pause_toggle_q;
  logic [DW-1:0] dim_cnt_q, dim_cnt_d;
  logic          frame_tick, coin_active, trig1;
  logic [7:0]    inp0_d, inp1_d, inp2_d;

  assign {joy1_s, joy2_s, mouse_s, vs_s, osd_s} = sync2_q;
  assign joy        = joy1_s | joy2_s;
  assign frame_tick = vs_s & ~vs_prev_q;

  always_comb begin
    dim_cnt_d = '0;
    if (pause_toggle_q)
      dim_cnt_d = (dim_cnt_q == DW'(DIM_CYCLES)) ? dim_cnt_q : dim_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q          <= '0;
      sync2_q          <= '0;
      vs_prev_q        <= 1'b0;
      pause_btn_prev_q <= 1'b0;
      pause_toggle_q   <= 1'b0;
      dim_cnt_q        <= '0;
      pause_o          <= 1'b0;
      dim_video_o      <= 1'b0;
    end else begin
      sync1_q          <= {joy1_i, joy2_i, mouse_btn_i, vs_strobe_i, osd_pause_i};
      sync2_q          <= sync1_q;
      vs_prev_q        <= vs_s;
      pause_btn_prev_q <= joy[JOY_PAUSE];
      if (joy[JOY_PAUSE] && !pause_btn_prev_q) pause_toggle_q <= ~pause_toggle_q;
      dim_cnt_q        <= dim_cnt_d;
      pause_o          <= hs_access_i | pause_toggle_q | osd_s;
      // Driven from the next count so dim drops together with pause.
      dim_video_o      <= (dim_cnt_d == DW'(DIM_CYCLES));
    end
  end

  sys1_coin_shaper #(
    .COIN_FRAMES (COIN_FRAMES)
  ) u_coin (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .coin_i        (joy[JOY_COIN]),
    .frame_tick_i  (frame_tick),
    .coin_active_o (coin_active)
  );

`ifdef INP_AUTOFIRE_EN
  localparam int AW = $clog2(AF_FRAMES + 1);
  logic [AW-1:0] af_cnt_q;
  logic          af_off_q, af_held;

  assign af_held = af_enable_i & joy[JOY_TRIG1];
  assign trig1   = joy[JOY_TRIG1] & ~(af_held & af_off_q);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      af_cnt_q <= '0;
      af_off_q <= 1'b0;
    end else if (!af_held) begin
      af_cnt_q <= '0;
      af_off_q <= 1'b0;
    end else if (frame_tick) begin
      if (af_cnt_q == AW'(AF_FRAMES - 1)) begin
        af_cnt_q <= '0;
        af_off_q <= ~af_off_q;
      end else begin
        af_cnt_q <= af_cnt_q + 1'b1;
      end
    end
  end
`else
  logic unused_af;
  assign unused_af = af_enable_i & (AF_FRAMES != 0);
  assign trig1     = joy[JOY_TRIG1];
`endif

  logic unused_bits;
  assign unused_bits = ^{joy[15:13], joy[10:9], sysmode_i[6], sysmode_i[4], sysmode_i[2:0]};

  always_comb begin
    logic [3:0] rstick;
    logic       t, ta, tb;
    rstick = joy1_s[7:4] | joy2_s[3:0];
    t      = trig1 | (|mouse_s);
    ta     = sysmode_i[SYSMODE_SWAP] ? joy[JOY_TRIG2] : trig1;
    tb     = sysmode_i[SYSMODE_SWAP] ? trig1 : joy[JOY_TRIG2];
    inp0_d = ~{joy[JOY_LEFT], joy[JOY_RIGHT], joy[JOY_UP], joy[JOY_DOWN],
               1'b0, ta, tb, joy[JOY_TRIG3]};
    inp2_d = ~{2'b00, joy[JOY_START2], joy[JOY_START1], 3'b000, coin_active};
    if (sysmode_i[SYSMODE_SPIN]) begin
      inp0_d = ~spin_i;
      inp2_d = ~{t, t, joy[JOY_START2], joy[JOY_START1], 3'b000, coin_active};
    end else if (sysmode_i[SYSMODE_WATER]) begin
      inp0_d = ~{joy1_s[JOY_LEFT], joy1_s[JOY_RIGHT], joy1_s[JOY_UP], joy1_s[JOY_DOWN],
                 rstick[JOY_LEFT], rstick[JOY_RIGHT], rstick[JOY_UP], rstick[JOY_DOWN]};
      inp2_d = ~{joy1_s[8], joy1_s[8], joy[JOY_START2], joy[JOY_START1], 3'b000, coin_active};
    end
    inp1_d = inp0_d;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      inp0_o <= 8'hFF;
      inp1_o <= 8'hFF;
      inp2_o <= 8'hFF;
    end else begin
      inp0_o <= inp0_d;
      inp1_o <= inp1_d;
      inp2_o <= inp2_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sys1_input_conditioner.sv
`default_nettype none
// ============================================================================
// tb_sys1_input_conditioner : scoreboard bench with reference byte model
// Rev 1.0
// ============================================================================
module tb_sys1_input_conditioner;

  localparam int COIN_FRAMES = 3;
  localparam int DIM_CYCLES  = 100;
  localparam int AF_FRAMES   = 2;
  localparam int FRAME       = 16;

  logic        clk = 0, reset_n = 0, vs = 0;
  logic [15:0] joy1 = 0, joy2 = 0;
  logic [7:0]  spin = 0, sysmode = 0;
  logic [2:0]  mouse = 0;
  logic        osd = 0, hs = 0, af_en = 0;
  logic [7:0]  inp0, inp1, inp2;
  logic        pause, dim;

  sys1_input_conditioner #(
    .COIN_FRAMES (COIN_FRAMES),
    .DIM_CYCLES  (DIM_CYCLES),
    .AF_FRAMES   (AF_FRAMES)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .vs_strobe_i (vs),
    .joy1_i      (joy1),
    .joy2_i      (joy2),
    .spin_i      (spin),
    .mouse_btn_i (mouse),
    .sysmode_i   (sysmode),
    .osd_pause_i (osd),
    .hs_access_i (hs),
    .af_enable_i (af_en),
    .inp0_o      (inp0),
    .inp1_o      (inp1),
    .inp2_o      (inp2),
    .pause_o     (pause),
    .dim_video_o (dim)
  );

  always #5 clk = ~clk;

  initial forever begin
    repeat (FRAME / 2) @(negedge clk);
    vs = 1;
    repeat (FRAME / 2) @(negedge clk);
    vs = 0;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reference: active-high "pressed" bytes built from the named controls, then inverted.
  function automatic logic [25:0] model(input logic [15:0] j1, input logic [15:0] j2,
                                        input logic [7:0] sp, input logic [2:0] mb,
                                        input logic [7:0] sm, input logic h, input logic o);
    logic [15:0] j;
    logic [3:0]  r;
    logic [7:0]  a0, a2;
    logic        t, ta, tb;
    j  = j1 | j2;
    a2 = 8'd0;
    if (j[7]) a2 = a2 + 8'h10;
    if (j[8]) a2 = a2 + 8'h20;
    if (sm[5]) begin
      a0 = sp;
      t  = j[4] || (mb != 3'd0);
      if (t) a2 = a2 + 8'hC0;
    end else if (sm[3]) begin
      r  = j1[7:4] | j2[3:0];
      a0 = {j1[1], j1[0], j1[3], j1[2], r[1], r[0], r[3], r[2]};
      if (j1[8]) a2 = a2 + 8'hC0;
    end else begin
      ta = sm[7] ? j[5] : j[4];
      tb = sm[7] ? j[4] : j[5];
      a0 = 8'd0;
      if (j[1]) a0 = a0 + 8'h80;
      if (j[0]) a0 = a0 + 8'h40;
      if (j[3]) a0 = a0 + 8'h20;
      if (j[2]) a0 = a0 + 8'h10;
      if (ta)   a0 = a0 + 8'h04;
      if (tb)   a0 = a0 + 8'h02;
      if (j[6]) a0 = a0 + 8'h01;
    end
    return {1'b0, h | o, ~a2, ~a0, ~a0};
  endfunction

  typedef struct packed {
    int          due;
    int          id;
    logic [25:0] exp;
  } sb_t;
  sb_t sb[$];
  int  sb_id = 0;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      sb_t e;
      e = sb.pop_front();
      chk($sformatf("sb%0d {dim,pause,inp2,inp1,inp0}", e.id),
          {6'd0, dim, pause, inp2, inp1, inp0}, {6'd0, e.exp});
    end
  end

  task automatic apply(input logic [15:0] j1, input logic [15:0] j2, input logic [7:0] sp,
                       input logic [2:0] mb, input logic [7:0] sm, input logic h, input logic o);
    sb_t e;
    @(negedge clk);
    joy1 = j1; joy2 = j2; spin = sp; mouse = mb; sysmode = sm; hs = h; osd = o;
    e.due = cyc + 3;
    e.id  = sb_id++;
    e.exp = model(j1, j2, sp, mb, sm, h, o);
    sb.push_back(e);
    repeat (5) @(negedge clk);
  endtask

  int  pulses = 0, cur_w = 0, last_w = 0;
  logic prev_c = 1;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_c = 1;
      cur_w  = 0;
    end else begin
      if (!inp2[0]) cur_w++;
      if (prev_c && !inp2[0]) pulses++;
      if (!prev_c && inp2[0]) begin
        last_w = cur_w;
        cur_w  = 0;
      end
      prev_c = inp2[0];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, n, trans;
    logic s, sp;

    repeat (3) @(negedge clk);
    chk("reset inp0", inp0, 8'hFF);
    chk("reset inp1", inp1, 8'hFF);
    chk("reset inp2", inp2, 8'hFF);
    chk("reset pause", pause, 0);
    chk("reset dim", dim, 0);
    reset_n = 1;
    repeat (4) @(negedge clk);

    apply(16'h0011, 16'h0000, 8'h00, 3'b000, 8'h00, 0, 0);  // RIGHT|trig1, no swap
    apply(16'h0011, 16'h0000, 8'h00, 3'b000, 8'h80, 0, 0);  // swapped triggers
    apply(16'h0000, 16'h0000, 8'h5A, 3'b001, 8'h20, 0, 0);  // spinner
    apply(16'h01A5, 16'h0003, 8'h00, 3'b000, 8'h08, 0, 0);  // water match
    apply(16'h0000, 16'h0010, 8'h33, 3'b000, 8'h28, 0, 1);  // spinner beats water

    for (int i = 0; i < 40; i++) begin
      apply(16'($urandom) & 16'hE7FF, 16'($urandom) & 16'hE7FF, 8'($urandom),
            3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    apply(16'h0000, 16'h0000, 8'h00, 3'b000, 8'h00, 0, 0);

    // Held coin: exactly one pulse, width within COIN_FRAMES frame ticks.
    p0 = pulses;
    @(negedge clk); joy2 = 16'h0800;
    repeat (20 * FRAME) @(negedge clk);
    chk("coin held pulse count", pulses - p0, 1);
    chk("coin width in window", (last_w > (COIN_FRAMES - 1) * FRAME && last_w <= COIN_FRAMES * FRAME), 1);
    joy2 = 0;
    repeat (3 * FRAME) @(negedge clk);
    joy1 = 16'h0800;
    repeat (6 * FRAME) @(negedge clk);
    chk("coin repress pulse count", pulses - p0, 2);
    chk("coin repress width", (last_w > (COIN_FRAMES - 1) * FRAME && last_w <= COIN_FRAMES * FRAME), 1);
    joy1 = 0;
    repeat (3 * FRAME) @(negedge clk);

    // Reset in the middle of a coin pulse.
    hs = 1;
    joy1 = 16'h0800;
    n = 0;
    while (inp2[0] !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    chk("coin pulse started", inp2[0], 0);
    repeat (10) @(negedge clk);
    chk("pause from hs before reset", pause, 1);
    reset_n = 0; joy1 = 0; hs = 0;
    #1;
    chk("midreset inp0", inp0, 8'hFF);
    chk("midreset inp1", inp1, 8'hFF);
    chk("midreset inp2", inp2, 8'hFF);
    chk("midreset pause", pause, 0);
    repeat (3) @(negedge clk);
    reset_n = 1;
    p0 = pulses;
    repeat (4 * FRAME) @(negedge clk);
    chk("no coin after reset", {pulses - p0, 24'(inp2)}, {32'd0} | 32'h0000_00FF);

    // Pause toggle and dim timer.
    joy1 = 16'h1000;
    repeat (4) @(negedge clk);
    joy1 = 0;
    n = 0;
    while (pause !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("pause after toggle", pause, 1);
    n = 0;
    while (dim !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("dim delay window", (n >= DIM_CYCLES - 5 && n <= DIM_CYCLES + 5), 1);
    repeat (5) @(negedge clk);
    chk("dim held", dim, 1);
    joy2 = 16'h1000;
    repeat (4) @(negedge clk);
    joy2 = 0;
    n = 0;
    while (pause !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk("pause cleared", pause, 0);
    chk("dim cleared with pause", dim, 0);
    hs = 1;
    repeat (4) @(negedge clk);
    chk("pause from hs", pause, 1);
    repeat (150) @(negedge clk);
    chk("hs never dims", dim, 0);
    hs = 0;
    repeat (4) @(negedge clk);

    // Trig1 held with autofire requested.
    af_en = 1;
    @(posedge vs);
    repeat (FRAME / 2) @(negedge clk);
    joy1 = 16'h0010;
    repeat (4) @(negedge clk);
    s = inp0[2];
    chk("trig1 asserted on press", s, 0);
    trans = 0;
    sp = s;
    for (int f = 0; f < 8; f++) begin
      @(posedge vs);
      repeat (FRAME / 2) @(negedge clk);
      s = inp0[2];
      if (s != sp) trans++;
      sp = s;
    end
`ifdef INP_AUTOFIRE_EN
    chk("autofire toggles", trans, 8 / AF_FRAMES);
`else
    chk("trig1 steady", trans, 0);
`endif
    joy1 = 0; af_en = 0;
    repeat (4) @(negedge clk);

    n = 0;
    while (sb.size() > 0 && n < 50) begin @(negedge clk); n++; end
    chk("scoreboard drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
